ahb3lite_mem_slave_gen2: RTL and testbench

- Parametrised AHB-Lite slave that fronts a single-port word memory. It sits between the AHB-Lite interconnect and the memory macro.
- Adds these capabilities:
  - configurable data and address width, memory size and wait states
  - byte-lane write strobes derived from HSIZE/HADDR
  - burst-address checking for INCR, INCRx and WRAPx bursts
  - two-cycle ERROR response
- Uses the ahb3lite_pkg types HTRANS_state, HBURST_Type and HRESP_state.

---
 rtl/ahb3lite_mem_slave_gen2.sv | 183 ++++++++++++++++++
 tb/tb_ahb3lite_mem_slave_gen2.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_mem_slave_gen2.sv
// AHB-Lite slave in front of a single-port word memory.
// Accepts INCR/INCRx/WRAPx bursts, checks beat addresses, inserts wait states and
// answers illegal transfers with a two-cycle ERROR response.

package ahb3lite_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} HTRANS_state;
  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } HBURST_Type;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} HRESP_state;
endpackage

module ahb3lite_mem_slave_gen2
  import ahb3lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                                          HCLK,
  input  logic                                          HRESET,
  input  logic                                          HSEL,
  input  logic [ADDR_WIDTH-1:0]                         HADDR,
  input  logic                                          HWRITE,
  input  logic [2:0]                                    HSIZE,
  input  HBURST_Type                                    HBURST,
  input  HTRANS_state                                   HTRANS,
  input  logic [DATA_WIDTH-1:0]                         HWDATA,
  input  logic                                          HREADY,
  output logic                                          HREADYOUT,
  output HRESP_state                                    HRESP,
  output logic [DATA_WIDTH-1:0]                         HRDATA,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    mem_addr,
  output logic                                          mem_we,
  output logic [DATA_WIDTH/8-1:0]                       mem_be,
  output logic [DATA_WIDTH-1:0]                         mem_wdata,
  output logic                                          mem_re,
  input  logic [DATA_WIDTH-1:0]                         mem_rdata,
  output logic [4:0]                                    burst_beat
);

  localparam int unsigned STRB   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB);
  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  HBURST_Type            burst_q;
  logic                  burst_act_q;
  logic [3:0]            wait_cnt_q;

  logic                  can_accept, accept, idle_seen;
  logic                  addr_bad, size_bad, align_bad, seq_bad, check_fail;
  logic [ADDR_WIDTH-1:0] inc, nxt_lin, wrap_mask, exp_addr, align_mask;
  logic [STRB-1:0]       be_new;
  int unsigned           be_off, be_len;

  // Address-phase qualification: only states driving HREADYOUT=1 can take a new transfer.
  always_comb begin
    can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    accept     = can_accept && HSEL && HREADY && ((HTRANS == NONSEQ) || (HTRANS == SEQ));
    idle_seen  = can_accept && HSEL && HREADY && (HTRANS == IDLE);
  end

  // Next beat address of the active burst; non-wrapping bursts use an all-ones mask.
  always_comb begin
    inc     = ADDR_WIDTH'(1) << size_q;
    nxt_lin = addr_q + inc;
    case (burst_q)
      WRAP4:   wrap_mask = (ADDR_WIDTH'(4) << size_q) - ADDR_WIDTH'(1);
      WRAP8:   wrap_mask = (ADDR_WIDTH'(8) << size_q) - ADDR_WIDTH'(1);
      WRAP16:  wrap_mask = (ADDR_WIDTH'(16) << size_q) - ADDR_WIDTH'(1);
      default: wrap_mask = '1;
    endcase
    exp_addr = (addr_q & ~wrap_mask) | (nxt_lin & wrap_mask);
  end

  // Legality checks on the incoming address phase.
  always_comb begin
    addr_bad   = |(HADDR >> MEM_AW);
    size_bad   = HSIZE > 3'(OFF_W);
    align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    align_bad  = |(HADDR & align_mask);
    seq_bad    = (HTRANS == SEQ) && (!burst_act_q || (HADDR != exp_addr));
    check_fail = addr_bad | size_bad | align_bad | seq_bad;
  end

  // Byte lanes covered by the incoming transfer.
  always_comb begin
    be_off = 32'(HADDR[OFF_W-1:0]);
    be_len = 32'(1) << HSIZE;
    be_new = '0;
    for (int unsigned i = 0; i < STRB; i++) begin
      be_new[i] = (i >= be_off) && (i < be_off + be_len);
    end
  end

  // Transfer FSM with registered bus and memory-strobe outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      HREADYOUT   <= 1'b1;
      HRESP       <= OKAY;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      burst_beat  <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      burst_q     <= SINGLE;
      burst_act_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state_q)
        StWait: begin
          if (wait_cnt_q == 4'd0) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
            mem_we    <= write_q;
            mem_re    <= !write_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= ERROR;
        end
        default: begin
          if (accept) begin
            addr_q   <= HADDR;
            write_q  <= HWRITE;
            size_q   <= HSIZE;
            burst_q  <= HBURST;
            mem_addr <= HADDR[ADDR_WIDTH-1:OFF_W];
            if (check_fail) begin
              state_q     <= StErr1;
              HREADYOUT   <= 1'b0;
              HRESP       <= ERROR;
              burst_act_q <= 1'b0;
            end else begin
              HRESP       <= OKAY;
              mem_be      <= HWRITE ? be_new : '0;
              burst_beat  <= (HTRANS == SEQ) ? burst_beat + 5'd1 : 5'd0;
              // A SINGLE transfer cannot be followed by SEQ.
              burst_act_q <= (HTRANS == SEQ) || (HBURST != SINGLE);
              if (WAIT_STATES > 0) begin
                state_q    <= StWait;
                HREADYOUT  <= 1'b0;
                wait_cnt_q <= 4'(WAIT_STATES - 1);
              end else begin
                state_q   <= StData;
                HREADYOUT <= 1'b1;
                mem_we    <= HWRITE;
                mem_re    <= !HWRITE;
              end
            end
          end else begin
            // IDLE/BUSY or no selection: zero-wait OKAY, burst_beat held.
            state_q   <= StIdle;
            HREADYOUT <= 1'b1;
            HRESP     <= OKAY;
            if (idle_seen) burst_act_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mem_wdata = HWDATA;
  assign HRDATA    = mem_re ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb3lite_mem_slave_gen2.sv
// Directed bench: zero-wait instance driven from a vector table plus a reset-abort
// sequence, then a two-wait-state instance from a second table.

module tb_ahb3lite_mem_slave_gen2;
  import ahb3lite_pkg::*;

  typedef struct {
    HTRANS_state trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    HBURST_Type  burst;
    logic [31:0] wdata;
    logic        rdy;
    HRESP_state  resp;
    logic        we;
    logic        re;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [4:0]  beat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic mem_clr;

  // zero-wait instance
  logic a_rst, a_hsel, a_hwrite, a_hready, a_hreadyout, a_mem_we, a_mem_re;
  logic [31:0] a_haddr, a_hwdata, a_hrdata, a_mem_wdata, a_mem_rdata;
  logic [2:0] a_hsize;
  HBURST_Type a_hburst;
  HTRANS_state a_htrans;
  HRESP_state a_hresp;
  logic [29:0] a_mem_addr;
  logic [3:0] a_mem_be;
  logic [4:0] a_beat;
  logic [31:0] a_mem [1024];

  // two-wait-state instance
  logic w_rst, w_hsel, w_hwrite, w_hready, w_hreadyout, w_mem_we, w_mem_re;
  logic [31:0] w_haddr, w_hwdata, w_hrdata, w_mem_wdata, w_mem_rdata;
  logic [2:0] w_hsize;
  HBURST_Type w_hburst;
  HTRANS_state w_htrans;
  HRESP_state w_hresp;
  logic [29:0] w_mem_addr;
  logic [3:0] w_mem_be;
  logic [4:0] w_beat;
  logic [31:0] w_mem [1024];

  assign a_hready = a_hreadyout;
  assign w_hready = w_hreadyout;
  assign a_mem_rdata = a_mem[a_mem_addr[9:0]];
  assign w_mem_rdata = w_mem[w_mem_addr[9:0]];

  ahb3lite_mem_slave_gen2 #(.WAIT_STATES(0)) u_dut (
    .HCLK(clk), .HRESET(a_rst), .HSEL(a_hsel), .HADDR(a_haddr), .HWRITE(a_hwrite),
    .HSIZE(a_hsize), .HBURST(a_hburst), .HTRANS(a_htrans), .HWDATA(a_hwdata),
    .HREADY(a_hready), .HREADYOUT(a_hreadyout), .HRESP(a_hresp), .HRDATA(a_hrdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_re(a_mem_re), .mem_rdata(a_mem_rdata), .burst_beat(a_beat)
  );

  ahb3lite_mem_slave_gen2 #(.WAIT_STATES(2)) u_dut_ws (
    .HCLK(clk), .HRESET(w_rst), .HSEL(w_hsel), .HADDR(w_haddr), .HWRITE(w_hwrite),
    .HSIZE(w_hsize), .HBURST(w_hburst), .HTRANS(w_htrans), .HWDATA(w_hwdata),
    .HREADY(w_hready), .HREADYOUT(w_hreadyout), .HRESP(w_hresp), .HRDATA(w_hrdata),
    .mem_addr(w_mem_addr), .mem_we(w_mem_we), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
    .mem_re(w_mem_re), .mem_rdata(w_mem_rdata), .burst_beat(w_beat)
  );

  // Byte-lane memory models
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 1024; k++) begin
        a_mem[k] <= '0;
        w_mem[k] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (a_mem_we && a_mem_be[b]) a_mem[a_mem_addr[9:0]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
        if (w_mem_we && w_mem_be[b]) w_mem[w_mem_addr[9:0]][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  function automatic vec_t mk(input HTRANS_state trans, input logic [31:0] addr,
                              input logic write, input logic [2:0] size,
                              input HBURST_Type burst, input logic [31:0] wdata,
                              input logic rdy, input HRESP_state resp, input logic we,
                              input logic re, input logic [29:0] maddr, input logic [3:0] be,
                              input logic [31:0] rdata, input logic [4:0] beat);
    vec_t v;
    v.trans = trans; v.addr = addr; v.write = write; v.size = size; v.burst = burst;
    v.wdata = wdata; v.rdy = rdy; v.resp = resp; v.we = we; v.re = re; v.maddr = maddr;
    v.be = be; v.rdata = rdata; v.beat = beat;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input bit sel, input vec_t v);
    if (sel) begin
      w_hsel = 1'b1; w_htrans = v.trans; w_haddr = v.addr; w_hwrite = v.write;
      w_hsize = v.size; w_hburst = v.burst; w_hwdata = v.wdata;
    end else begin
      a_hsel = 1'b1; a_htrans = v.trans; a_haddr = v.addr; a_hwrite = v.write;
      a_hsize = v.size; a_hburst = v.burst; a_hwdata = v.wdata;
    end
  endtask

  task automatic check_vec(input bit sel, input vec_t v, input int idx);
    chk("hreadyout", idx, 64'(sel ? w_hreadyout : a_hreadyout), 64'(v.rdy));
    chk("hresp", idx, 64'(sel ? w_hresp : a_hresp), 64'(v.resp));
    chk("mem_we", idx, 64'(sel ? w_mem_we : a_mem_we), 64'(v.we));
    chk("mem_re", idx, 64'(sel ? w_mem_re : a_mem_re), 64'(v.re));
    chk("hrdata", idx, 64'(sel ? w_hrdata : a_hrdata), 64'(v.rdata));
    chk("burst_beat", idx, 64'(sel ? w_beat : a_beat), 64'(v.beat));
    if (v.we) begin
      chk("mem_addr", idx, 64'(sel ? w_mem_addr : a_mem_addr), 64'(v.maddr));
      chk("mem_be", idx, 64'(sel ? w_mem_be : a_mem_be), 64'(v.be));
    end
  endtask

  task automatic step(input bit sel, input vec_t v, input int idx);
    apply(sel, v);
    #1;
    check_vec(sel, v, idx);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_hreadyout", idx, 64'(a_hreadyout), 64'(1));
    chk("rst_hresp", idx, 64'(a_hresp), 64'(OKAY));
    chk("rst_mem_we", idx, 64'(a_mem_we), 64'(0));
    chk("rst_mem_re", idx, 64'(a_mem_re), 64'(0));
    chk("rst_mem_addr", idx, 64'(a_mem_addr), 64'(0));
    chk("rst_mem_be", idx, 64'(a_mem_be), 64'(0));
    chk("rst_burst_beat", idx, 64'(a_beat), 64'(0));
    chk("rst_hrdata", idx, 64'(a_hrdata), 64'(0));
  endtask

  vec_t av[$];
  vec_t wv[$];

  initial begin
    // {trans, addr, wr, size, burst, wdata | rdy, resp, we, re, maddr, be, rdata, beat}
    av.push_back(mk(NONSEQ, 32'h10, 1'b1, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(NONSEQ, 32'h10, 1'b0, 3'd2, SINGLE, 32'hDEADBEEF,
                    1'b1, OKAY, 1'b1, 1'b0, 30'h4, 4'hF, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'hDEADBEEF, 5'd0));
    av.push_back(mk(NONSEQ, 32'h13, 1'b1, 3'd0, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd0, SINGLE, 32'hAA000000,
                    1'b1, OKAY, 1'b1, 1'b0, 30'h4, 4'h8, 32'h0, 5'd0));
    av.push_back(mk(NONSEQ, 32'h10, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    // out-of-range read accepted while the previous read completes
    av.push_back(mk(NONSEQ, 32'h1000, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'hAAADBEEF, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    // misaligned word read
    av.push_back(mk(NONSEQ, 32'h12, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    // halfword write accepted during ERR2
    av.push_back(mk(NONSEQ, 32'h22, 1'b1, 3'd1, SINGLE, 32'h0,
                    1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    // oversize (doubleword) read presented during halfword data phase
    av.push_back(mk(NONSEQ, 32'h24, 1'b0, 3'd3, SINGLE, 32'h12345678,
                    1'b1, OKAY, 1'b1, 1'b0, 30'h8, 4'hC, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(NONSEQ, 32'h20, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'h12340000, 5'd0));
    // WRAP4 write burst 0x38, 0x3C, 0x30, 0x34
    av.push_back(mk(NONSEQ, 32'h38, 1'b1, 3'd2, WRAP4, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(SEQ, 32'h3C, 1'b1, 3'd2, WRAP4, 32'h11,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hE, 4'hF, 32'h0, 5'd0));
    av.push_back(mk(SEQ, 32'h30, 1'b1, 3'd2, WRAP4, 32'h22,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hF, 4'hF, 32'h0, 5'd1));
    av.push_back(mk(SEQ, 32'h34, 1'b1, 3'd2, WRAP4, 32'h33,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hC, 4'hF, 32'h0, 5'd2));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, WRAP4, 32'h44,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hD, 4'hF, 32'h0, 5'd3));
    // WRAP4 read burst with a bad third beat (0x40 instead of 0x30)
    av.push_back(mk(NONSEQ, 32'h38, 1'b0, 3'd2, WRAP4, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd3));
    av.push_back(mk(SEQ, 32'h3C, 1'b0, 3'd2, WRAP4, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'h11, 5'd0));
    av.push_back(mk(SEQ, 32'h40, 1'b0, 3'd2, WRAP4, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'h22, 5'd1));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, WRAP4, 32'h0,
                    1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd1));
    av.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, WRAP4, 32'h0,
                    1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd1));
    // INCR write burst with BUSY between beats
    av.push_back(mk(NONSEQ, 32'h30, 1'b1, 3'd2, INCR, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd1));
    av.push_back(mk(BUSY, 32'h34, 1'b1, 3'd2, INCR, 32'h55,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hC, 4'hF, 32'h0, 5'd0));
    av.push_back(mk(SEQ, 32'h34, 1'b1, 3'd2, INCR, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    av.push_back(mk(SEQ, 32'h38, 1'b1, 3'd2, INCR, 32'h66,
                    1'b1, OKAY, 1'b1, 1'b0, 30'hD, 4'hF, 32'h0, 5'd1));

    // WAIT_STATES=2: write 0x40, read it back, then an out-of-range read
    wv.push_back(mk(NONSEQ, 32'h40, 1'b1, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'hCAFEF00D,
                    1'b0, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'hCAFEF00D,
                    1'b0, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(NONSEQ, 32'h40, 1'b0, 3'd2, SINGLE, 32'hCAFEF00D,
                    1'b1, OKAY, 1'b1, 1'b0, 30'h10, 4'hF, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b1, 30'h0, 4'h0, 32'hCAFEF00D, 5'd0));
    wv.push_back(mk(NONSEQ, 32'h2000, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    wv.push_back(mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                    1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));

    mem_clr = 1'b1;
    a_rst = 1'b1;
    w_rst = 1'b1;
    apply(1'b0, mk(IDLE, 32'h0, 1'b0, 3'd0, SINGLE, 32'h0,
                   1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    apply(1'b1, mk(IDLE, 32'h0, 1'b0, 3'd0, SINGLE, 32'h0,
                   1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(-1);
    mem_clr = 1'b0;
    a_rst = 1'b0;

    for (int i = 0; i < av.size(); i++) step(1'b0, av[i], i);

    // Reset during the 0x38 data phase while SEQ 0x3C is presented: 0x3C must never be written
    a_rst = 1'b1;
    step(1'b0, mk(SEQ, 32'h3C, 1'b1, 3'd2, INCR, 32'h77,
                  1'b1, OKAY, 1'b1, 1'b0, 30'hE, 4'hF, 32'h0, 5'd2), 100);
    apply(1'b0, mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h99,
                   1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    #1;
    chk_reset_vals(101);
    @(posedge clk);
    #1;
    // SEQ with no active burst after reset
    a_rst = 1'b0;
    apply(1'b0, mk(SEQ, 32'h40, 1'b0, 3'd2, INCR, 32'h0,
                   1'b1, OKAY, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0));
    #1;
    chk_reset_vals(102);
    @(posedge clk);
    #1;
    step(1'b0, mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                  1'b0, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0), 103);
    step(1'b0, mk(IDLE, 32'h0, 1'b0, 3'd2, SINGLE, 32'h0,
                  1'b1, ERROR, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 5'd0), 104);

    chk("mem_word4", 0, 64'(a_mem[4]), 64'h0000_0000_AAAD_BEEF);
    chk("mem_word8", 0, 64'(a_mem[8]), 64'h0000_0000_1234_0000);
    chk("mem_wordC", 0, 64'(a_mem[12]), 64'h55);
    chk("mem_wordD", 0, 64'(a_mem[13]), 64'h66);
    chk("mem_wordE", 0, 64'(a_mem[14]), 64'h77);
    chk("mem_wordF", 0, 64'(a_mem[15]), 64'h22);

    w_rst = 1'b0;
    for (int i = 0; i < wv.size(); i++) step(1'b1, wv[i], 200 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
